traffic_config_ctrl: RTL and testbench
======================================

TRAFFIC_CONFIG_CTRL -- requirements
Module: traffic_config_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4: consecutive stable cycles required to accept a button level.
REQ-002 SHALL have parameter GREEN_DEF, default 25: green time after reset, in seconds.
REQ-003 SHALL have parameter YELLOW_DEF, default 3: yellow time after reset, in seconds.
REQ-004 SHALL have port clk  input  1  single system clock; all state SHALL be clocked on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port btn_mode  input  1  raw, asynchronous mode button.
REQ-007 SHALL have port btn_sel  input  1  raw edit-field select button.
REQ-008 SHALL have port btn_inc  input  1  raw increment button.
REQ-009 SHALL have port btn_dec  input  1  raw decrement button.
REQ-010 SHALL have port enable  output  3  mode to the sequencer: 100 AUTO, 010 MANUAL, 001 NIGHT, 000 CONFIG.
REQ-011 SHALL have port greenTime  output  7  committed green time.
REQ-012 SHALL have port yellowTime  output  7  committed yellow time.
REQ-013 SHALL have port redTime  output  7  committed red time.
REQ-014 SHALL have port edit_field  output  1  field under edit: 0 GREEN, 1 YELLOW.
REQ-015 SHALL have port shadow_time  output  7  value of the field under edit, for display.

Function
REQ-016 SHALL pass each button through a 2-FF synchronizer, then a debouncer that accepts a new level after DEBOUNCE_CYCLES consecutive equal samples; any differing sample SHALL clear the count.
REQ-017 SHALL emit a one-cycle press pulse when a debounced level goes 0->1; release SHALL produce no pulse, and a held button SHALL produce exactly one pulse.
REQ-018 SHALL update a register on the clock edge following its press pulse; a raw edge held stable SHALL change enable on edge DEBOUNCE_CYCLES+3 after the first edge sampling it high.
REQ-019 SHALL run a mode FSM with states AUTO, MANUAL, NIGHT, CONFIG; a mode press SHALL step AUTO->MANUAL->NIGHT->CONFIG->AUTO.
REQ-020 SHALL hold enable as a registered one-hot encoding of the FSM state, per REQ-010.
REQ-021 SHALL copy the committed green and yellow times into shadow registers and set edit_field=GREEN on entry to CONFIG.
REQ-022 SHALL, in CONFIG only, toggle edit_field on each sel press.
REQ-023 SHALL, in CONFIG only, add 1 to the selected shadow field on inc and subtract 1 on dec.
REQ-024 SHALL clamp shadow green to 5..90 and shadow yellow to 2..9; inc at the maximum or dec at the minimum SHALL leave the value unchanged.
REQ-025 SHALL commit the shadow registers to greenTime/yellowTime on the CONFIG->AUTO transition, so they are valid on the same edge enable becomes 100.
REQ-026 SHALL hold greenTime/yellowTime/redTime constant at all other times.
REQ-027 SHALL set redTime = greenTime + yellowTime, registered; the maximum value is 99, so no overflow occurs in 7 bits.
REQ-028 SHALL drive shadow_time with the committed value of the selected field when outside CONFIG.
REQ-029 SHALL, on simultaneous pulses, apply only the highest priority (mode > sel > inc > dec) and drop the rest.
REQ-030 SHALL, when inc and dec pulse together with no higher press, ignore both.
REQ-031 SHALL ignore sel/inc/dec pulses outside CONFIG.

Reset
REQ-032 SHALL, while reset is low, asynchronously force: FSM=AUTO, enable=100, greenTime=GREEN_DEF, yellowTime=YELLOW_DEF, redTime=GREEN_DEF+YELLOW_DEF, edit_field=0, shadows=defaults, synchronizers/debouncers/counters=0.
REQ-033 SHALL, on reset mid-CONFIG, discard uncommitted shadow edits.
REQ-034 SHALL, after reset release, not emit a pulse for a button already held high until it is released and pressed again.

Structure
REQ-035 SHALL take mode encodings, field encodings, and min/max limits from a shared package traffic_pkg.
REQ-036 SHALL implement sync+debounce+edge in sub-module btn_debounce, instantiated four times.

Verification
REQ-037 SHALL cover: reset low mid-run -> enable=100, greenTime=25, yellowTime=3, redTime=28 immediately.
REQ-038 SHALL cover: btn_mode high 7 cycles -> enable 100->010 exactly once on edge 7; held 50 cycles -> no further change.
REQ-039 SHALL cover: bounce 1-0-1-0 at 1-cycle spacing, then stable high -> one pulse only, after 4 stable cycles.
REQ-040 SHALL cover: enter CONFIG, 3 inc -> shadow_time=28; sel, 10 inc -> yellow=9 (clamped); mode -> enable=100, greenTime=28, yellowTime=9, redTime=37.
REQ-041 SHALL cover: in CONFIG at green=5, dec -> stays 5; inc+dec same cycle -> unchanged; inc in AUTO -> no effect.
REQ-042 SHALL cover: edits in CONFIG, then reset -> outputs return to defaults, edits lost.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared encodings and limits for the traffic light configuration controller.
// Mode/field encodings, edit limits and small helpers.
package traffic_pkg;

  typedef enum logic [1:0] {
    S_AUTO,
    S_MANUAL,
    S_NIGHT,
    S_CONFIG
  } mode_t;

  localparam logic [2:0] EN_AUTO   = 3'b100;
  localparam logic [2:0] EN_MANUAL = 3'b010;
  localparam logic [2:0] EN_NIGHT  = 3'b001;
  localparam logic [2:0] EN_CONFIG = 3'b000;

  localparam logic FIELD_GREEN  = 1'b0;
  localparam logic FIELD_YELLOW = 1'b1;

  localparam logic [6:0] GREEN_MIN  = 7'd5;
  localparam logic [6:0] GREEN_MAX  = 7'd90;
  localparam logic [6:0] YELLOW_MIN = 7'd2;
  localparam logic [6:0] YELLOW_MAX = 7'd9;

  function automatic mode_t next_mode(mode_t m);
    mode_t r;
    r = S_AUTO;
    unique case (m)
      S_AUTO:   r = S_MANUAL;
      S_MANUAL: r = S_NIGHT;
      S_NIGHT:  r = S_CONFIG;
      S_CONFIG: r = S_AUTO;
      default:  r = S_AUTO;
    endcase
    return r;
  endfunction

  function automatic logic [2:0] mode_enable(mode_t m);
    logic [2:0] r;
    r = EN_AUTO;
    unique case (m)
      S_AUTO:   r = EN_AUTO;
      S_MANUAL: r = EN_MANUAL;
      S_NIGHT:  r = EN_NIGHT;
      S_CONFIG: r = EN_CONFIG;
      default:  r = EN_AUTO;
    endcase
    return r;
  endfunction

  // Saturating single step: holds at the limit instead of wrapping.
  function automatic logic [6:0] step_time(
    logic [6:0] v,
    logic       up,
    logic [6:0] lo,
    logic [6:0] hi
  );
    logic [6:0] r;
    r = v;
    if (up) begin
      if (v < hi) r = v + 7'd1;
    end else begin
      if (v > lo) r = v - 7'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioning: 2-FF synchronizer, level debouncer, rising-edge pulse.
// A button held through reset stays disarmed until seen released.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic          level_d;
  logic          armed;
  logic [1:0]    prime;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      armed   <= 1'b0;
      prime   <= 2'd0;
      cnt     <= '0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      level_d <= level;
      // sync2 only reflects the pin once the pipeline has refilled
      if (prime != 2'd2) prime <= prime + 2'd1;
      else if (!sync2) armed <= 1'b1;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign press = level & ~level_d & armed;

endmodule

// File: rtl/traffic_config_ctrl.sv
// Mode sequencing and green/yellow time editing for the traffic light.
// Edits live in shadow registers and commit when CONFIG exits to AUTO.
module traffic_config_ctrl
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int GREEN_DEF       = 25,
  parameter int YELLOW_DEF      = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_sel,
  input  logic       btn_inc,
  input  logic       btn_dec,
  output logic [2:0] enable,
  output logic [6:0] greenTime,
  output logic [6:0] yellowTime,
  output logic [6:0] redTime,
  output logic       edit_field,
  output logic [6:0] shadow_time
);

  logic p_mode, p_sel, p_inc, p_dec;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode (
    .clk(clk), .reset(reset), .raw(btn_mode), .press(p_mode)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sel (
    .clk(clk), .reset(reset), .raw(btn_sel), .press(p_sel)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc (
    .clk(clk), .reset(reset), .raw(btn_inc), .press(p_inc)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dec (
    .clk(clk), .reset(reset), .raw(btn_dec), .press(p_dec)
  );

  mode_t      state, state_n;
  logic       field_n;
  logic [6:0] sg, sy, sg_n, sy_n;
  logic [6:0] green_n, yellow_n;
  logic       in_cfg;
  logic       do_sel, do_inc, do_dec;

  assign in_cfg = (state == S_CONFIG);
  // Priority mode > sel > inc > dec; inc with dec cancels out.
  assign do_sel = !p_mode && p_sel;
  assign do_inc = !p_mode && !p_sel && p_inc && !p_dec;
  assign do_dec = !p_mode && !p_sel && p_dec && !p_inc;

  always_comb begin
    state_n  = state;
    field_n  = edit_field;
    sg_n     = sg;
    sy_n     = sy;
    green_n  = greenTime;
    yellow_n = yellowTime;
    unique case (1'b1)
      p_mode: begin
        state_n = next_mode(state);
        if (state == S_CONFIG) begin
          green_n  = sg;
          yellow_n = sy;
        end
        if (state_n == S_CONFIG) begin
          sg_n    = greenTime;
          sy_n    = yellowTime;
          field_n = FIELD_GREEN;
        end
      end
      do_sel: begin
        if (in_cfg) field_n = ~edit_field;
      end
      do_inc, do_dec: begin
        if (in_cfg) begin
          if (edit_field == FIELD_GREEN)
            sg_n = step_time(sg, do_inc, GREEN_MIN, GREEN_MAX);
          else
            sy_n = step_time(sy, do_inc, YELLOW_MIN, YELLOW_MAX);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_AUTO;
      enable     <= EN_AUTO;
      greenTime  <= 7'(GREEN_DEF);
      yellowTime <= 7'(YELLOW_DEF);
      redTime    <= 7'(GREEN_DEF + YELLOW_DEF);
      edit_field <= FIELD_GREEN;
      sg         <= 7'(GREEN_DEF);
      sy         <= 7'(YELLOW_DEF);
    end else begin
      state      <= state_n;
      enable     <= mode_enable(state_n);
      greenTime  <= green_n;
      yellowTime <= yellow_n;
      redTime    <= green_n + yellow_n;
      edit_field <= field_n;
      sg         <= sg_n;
      sy         <= sy_n;
    end
  end

  always_comb begin
    shadow_time = greenTime;
    if (in_cfg)
      shadow_time = (edit_field == FIELD_YELLOW) ? sy : sg;
    else
      shadow_time = (edit_field == FIELD_YELLOW) ? yellowTime : greenTime;
  end

endmodule

// File: tb/tb_traffic_config_ctrl.sv
// Bench for traffic_config_ctrl: directed timing scenarios plus randomized
// button commands checked against a command-level model.
module tb_traffic_config_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_mode = 1'b0;
  logic       btn_sel = 1'b0;
  logic       btn_inc = 1'b0;
  logic       btn_dec = 1'b0;
  logic [2:0] enable;
  logic [6:0] greenTime, yellowTime, redTime, shadow_time;
  logic       edit_field;

  traffic_config_ctrl #(
    .DEBOUNCE_CYCLES(4), .GREEN_DEF(25), .YELLOW_DEF(3)
  ) dut (
    .clk(clk), .reset(reset),
    .btn_mode(btn_mode), .btn_sel(btn_sel),
    .btn_inc(btn_inc), .btn_dec(btn_dec),
    .enable(enable), .greenTime(greenTime),
    .yellowTime(yellowTime), .redTime(redTime),
    .edit_field(edit_field), .shadow_time(shadow_time)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Command-level model: mode index 0..3 = AUTO, MANUAL, NIGHT, CONFIG
  int m_mode, m_green, m_yellow, m_sg, m_sy, m_field;

  function automatic void model_reset();
    m_mode = 0; m_green = 25; m_yellow = 3;
    m_sg = 25; m_sy = 3; m_field = 0;
  endfunction

  function automatic void model_apply(input logic [3:0] m);
    if (m[3]) begin
      if (m_mode == 3) begin
        m_green = m_sg; m_yellow = m_sy;
      end
      m_mode = (m_mode + 1) % 4;
      if (m_mode == 3) begin
        m_sg = m_green; m_sy = m_yellow; m_field = 0;
      end
    end else if (m_mode == 3) begin
      if (m[2]) m_field = 1 - m_field;
      else if (m[1] && !m[0]) begin
        if (m_field == 0) m_sg = (m_sg + 1 > 90) ? 90 : m_sg + 1;
        else m_sy = (m_sy + 1 > 9) ? 9 : m_sy + 1;
      end else if (m[0] && !m[1]) begin
        if (m_field == 0) m_sg = (m_sg - 1 < 5) ? 5 : m_sg - 1;
        else m_sy = (m_sy - 1 < 2) ? 2 : m_sy - 1;
      end
    end
  endfunction

  function automatic logic [31:0] exp_vec();
    logic [2:0] en;
    int sh;
    en = (m_mode == 3) ? 3'b000 : (3'b100 >> m_mode);
    if (m_mode == 3) sh = m_field ? m_sy : m_sg;
    else sh = m_field ? m_yellow : m_green;
    return {en, 7'(m_green), 7'(m_yellow), 7'(m_green + m_yellow),
            1'(m_field), 7'(sh)};
  endfunction

  function automatic logic [31:0] act_vec();
    return {enable, greenTime, yellowTime, redTime, edit_field, shadow_time};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] m);
    {btn_mode, btn_sel, btn_inc, btn_dec} = m;
    repeat (6) tick();
    {btn_mode, btn_sel, btn_inc, btn_dec} = 4'b0000;
    repeat (8) tick();
    model_apply(m);
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    #2;
    checks++;
    if ({enable, greenTime, yellowTime, redTime, edit_field, shadow_time}
        !== {3'b100, 7'd25, 7'd3, 7'd28, 1'b0, 7'd25}) begin
      failures++;
      $display("FAIL reset_async: got %h want enable=100 g=25 y=3 r=28",
               act_vec());
    end
    repeat (2) tick();
    reset = 1'b1;
    repeat (4) tick();
    model_reset();
    checks++;
    if (act_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL reset_release: got %h want %h", act_vec(), exp_vec());
    end
  endtask

  task automatic test_mode_timing();
    btn_mode = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k == 7) model_apply(4'b1000);
      checks++;
      if (act_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL mode_edge%0d: got %h want %h", k, act_vec(), exp_vec());
      end
    end
    repeat (43) tick();
    checks++;
    if (act_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL mode_held: got %h want %h", act_vec(), exp_vec());
    end
    btn_mode = 1'b0;
    repeat (8) tick();
  endtask

  task automatic test_bounce();
    btn_mode = 1'b1; tick();
    btn_mode = 1'b0; tick();
    btn_mode = 1'b1; tick();
    btn_mode = 1'b0; tick();
    btn_mode = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k == 7) model_apply(4'b1000);
      checks++;
      if (act_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL bounce_edge%0d: got %h want %h", k, act_vec(), exp_vec());
      end
    end
    repeat (20) tick();
    checks++;
    if (act_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL bounce_held: got %h want %h", act_vec(), exp_vec());
    end
    btn_mode = 1'b0;
    repeat (8) tick();
  endtask

  task automatic goto_config();
    for (int i = 0; i < 4 && m_mode != 3; i++) press(4'b1000);
    checks++;
    if (act_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL config_entry: got %h want %h", act_vec(), exp_vec());
    end
  endtask

  task automatic test_config_edit();
    goto_config();
    repeat (3) press(4'b0010);
    checks++;
    if (shadow_time !== 7'd28 || act_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL cfg_green_inc: got %0d want 28", shadow_time);
    end
    press(4'b0100);
    repeat (10) press(4'b0010);
    checks++;
    if (shadow_time !== 7'd9 || edit_field !== 1'b1) begin
      failures++;
      $display("FAIL cfg_yellow_clamp: got %0d want 9", shadow_time);
    end
    press(4'b1000);
    checks++;
    if ({enable, greenTime, yellowTime, redTime}
        !== {3'b100, 7'd28, 7'd9, 7'd37}) begin
      failures++;
      $display("FAIL cfg_commit: got en=%b g=%0d y=%0d r=%0d want 100/28/9/37",
               enable, greenTime, yellowTime, redTime);
    end
  endtask

  task automatic test_clamp();
    goto_config();
    repeat (23) press(4'b0001);
    checks++;
    if (shadow_time !== 7'd5) begin
      failures++;
      $display("FAIL clamp_down_to5: got %0d want 5", shadow_time);
    end
    press(4'b0001);
    checks++;
    if (shadow_time !== 7'd5) begin
      failures++;
      $display("FAIL clamp_min: got %0d want 5", shadow_time);
    end
    press(4'b0011);
    checks++;
    if (shadow_time !== 7'd5 || act_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL inc_dec_same: got %0d want 5", shadow_time);
    end
    press(4'b1000);
    checks++;
    if ({enable, greenTime, yellowTime, redTime}
        !== {3'b100, 7'd5, 7'd9, 7'd14}) begin
      failures++;
      $display("FAIL clamp_commit: got en=%b g=%0d r=%0d want 100/5/14",
               enable, greenTime, redTime);
    end
    press(4'b0010);
    press(4'b0100);
    checks++;
    if (act_vec() !== exp_vec() || shadow_time !== 7'd5) begin
      failures++;
      $display("FAIL auto_ignore: got %h want %h", act_vec(), exp_vec());
    end
  endtask

  task automatic test_reset_config();
    goto_config();
    repeat (2) press(4'b0010);
    press(4'b0100);
    press(4'b0010);
    reset = 1'b0;
    #2;
    checks++;
    if ({enable, greenTime, yellowTime, redTime, edit_field, shadow_time}
        !== {3'b100, 7'd25, 7'd3, 7'd28, 1'b0, 7'd25}) begin
      failures++;
      $display("FAIL reset_mid_config: got %h want defaults", act_vec());
    end
    btn_mode = 1'b1;
    repeat (3) tick();
    reset = 1'b1;
    model_reset();
    repeat (30) tick();
    checks++;
    if (act_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL held_at_reset: got %h want %h", act_vec(), exp_vec());
    end
    btn_mode = 1'b0;
    repeat (10) tick();
    press(4'b1000);
    checks++;
    if (enable !== 3'b010) begin
      failures++;
      $display("FAIL repress_after_reset: got %b want 010", enable);
    end
  endtask

  task automatic test_random();
    logic [3:0] m;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1) m = 4'($urandom_range(1, 15));
      else m = 4'b0001 << $urandom_range(0, 2);
      press(m);
      checks++;
      if (act_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL random%0d cmd=%b: got %h want %h",
                 i, m, act_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_mode_timing();
    test_bounce();
    test_config_edit();
    test_clamp();
    test_reset_config();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
